// File: rtl/register_file_pkg.sv
// Shared types and default datapath geometry for the architectural register bank.
package register_file_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } rf_state_t;

   localparam int unsigned RF_WIDTH = 16;
   localparam int unsigned RF_DEPTH = 8;
   localparam int unsigned RF_LANE  = 4;

endpackage

// File: rtl/regfile_lane_merge.sv
// Combinational lane-masked merge: lanes with mask set take new_data, others keep old_data.
module regfile_lane_merge
   import register_file_pkg::*;
#(
   parameter  int unsigned WIDTH = RF_WIDTH,
   parameter  int unsigned LANE  = RF_LANE,
   localparam int unsigned LANES = WIDTH / LANE
) (
   input  logic [WIDTH-1:0] old_data,
   input  logic [WIDTH-1:0] new_data,
   input  logic [LANES-1:0] mask,
   output logic [WIDTH-1:0] merged
);

   always_comb begin
      merged = old_data;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (mask[k]) begin
            merged[k*LANE +: LANE] = new_data[k*LANE +: LANE];
         end
      end
   end

endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register file: one lane-masked write port, two registered read ports
// with same-cycle write bypass, and a one-entry-per-cycle clear sweep after reset/clr.
module register_file
   import register_file_pkg::*;
#(
   parameter  int unsigned WIDTH    = RF_WIDTH,
   parameter  int unsigned DEPTH    = RF_DEPTH,
   parameter  int unsigned LANE     = RF_LANE,
   parameter  int unsigned ZERO_REG = 1,
   localparam int unsigned LANES    = WIDTH / LANE,
   localparam int unsigned AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [LANES-1:0] wmask,
   input  logic             re_a,
   input  logic [AW-1:0]    raddr_a,
   input  logic             re_b,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic             rvalid_a,
   output logic [WIDTH-1:0] rdata_b,
   output logic             rvalid_b,
   output logic             busy,
   output logic             wr_drop
);

   rf_state_t        state;
   logic [AW-1:0]    ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   logic             in_clear;
   logic             wr_zero;
   logic             wr_acc;
   logic             wr_rej;
   logic             blank;
   logic [WIDTH-1:0] merged;
   logic [WIDTH-1:0] rsel_a;
   logic [WIDTH-1:0] rsel_b;

   assign in_clear = (state == CLEAR);
   assign busy     = in_clear;
   assign wr_zero  = (ZERO_REG != 0) && (waddr == '0);
   assign wr_acc   = we && !in_clear && !clr && !wr_zero;
   assign wr_rej   = we && (in_clear || clr);
   assign blank    = in_clear || clr;

   // One merge feeds both the storage write and the read bypass.
   regfile_lane_merge #(
      .WIDTH (WIDTH),
      .LANE  (LANE)
   ) u_merge (
      .old_data (mem[waddr]),
      .new_data (wdata),
      .mask     (wmask),
      .merged   (merged)
   );

   // Storage has no reset so it can map to a single-write-port RAM.
   always_ff @(posedge clk) begin
      if (in_clear) begin
         mem[ptr] <= '0;
      end else if (wr_acc) begin
         mem[waddr] <= merged;
      end
   end

   always_comb begin
      rsel_a = mem[raddr_a];
      if (blank || ((ZERO_REG != 0) && (raddr_a == '0))) begin
         rsel_a = '0;
      end else if (wr_acc && (raddr_a == waddr)) begin
         rsel_a = merged;
      end
   end

   always_comb begin
      rsel_b = mem[raddr_b];
      if (blank || ((ZERO_REG != 0) && (raddr_b == '0))) begin
         rsel_b = '0;
      end else if (wr_acc && (raddr_b == waddr)) begin
         rsel_b = merged;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= CLEAR;
         ptr      <= '0;
         rdata_a  <= '0;
         rvalid_a <= 1'b0;
         rdata_b  <= '0;
         rvalid_b <= 1'b0;
         wr_drop  <= 1'b0;
      end else begin
         wr_drop  <= wr_rej;
         rvalid_a <= re_a;
         rvalid_b <= re_b;
         if (re_a) begin
            rdata_a <= rsel_a;
         end
         if (re_b) begin
            rdata_b <= rsel_b;
         end

         if (clr) begin
            state <= CLEAR;
            ptr   <= '0;
         end else if (in_clear) begin
            if (ptr == AW'(DEPTH - 1)) begin
               state <= IDLE;
               ptr   <= '0;
            end else begin
               ptr <= ptr + AW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (16x8, 4-bit lanes, zero register on).
module tb_register_file;

   logic        clk;
   logic        reset;
   logic        clr;
   logic        we;
   logic [2:0]  waddr;
   logic [15:0] wdata;
   logic [3:0]  wmask;
   logic        re_a;
   logic [2:0]  raddr_a;
   logic        re_b;
   logic [2:0]  raddr_b;
   logic [15:0] rdata_a;
   logic        rvalid_a;
   logic [15:0] rdata_b;
   logic        rvalid_b;
   logic        busy;
   logic        wr_drop;

   int n_assert = 0;
   int n_fail   = 0;
   int cnt;
   logic busy_before;

   register_file #(
      .WIDTH    (16),
      .DEPTH    (8),
      .LANE     (4),
      .ZERO_REG (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .wmask    (wmask),
      .re_a     (re_a),
      .raddr_a  (raddr_a),
      .re_b     (re_b),
      .raddr_b  (raddr_b),
      .rdata_a  (rdata_a),
      .rvalid_a (rvalid_a),
      .rdata_b  (rdata_b),
      .rvalid_b (rvalid_b),
      .busy     (busy),
      .wr_drop  (wr_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clr = 0; we = 0; waddr = '0; wdata = '0; wmask = '0;
      re_a = 0; raddr_a = '0; re_b = 0; raddr_b = '0;
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      step();
      step();
      chk("rst_rdata_a", rdata_a, 0);
      chk("rst_rdata_b", rdata_b, 0);
      chk("rst_rvalid_a", rvalid_a, 0);
      chk("rst_rvalid_b", rvalid_b, 0);
      chk("rst_wr_drop", wr_drop, 0);
      chk("rst_busy", busy, 1);

      // Reset sweep length
      reset = 0;
      cnt = 0;
      for (int i = 0; i < 20 && busy; i++) begin
         cnt++;
         step();
      end
      chk("reset_busy_len", cnt, 8);

      for (int a = 0; a < 8; a++) begin
         re_a = 1; raddr_a = 3'(a);
         re_b = 1; raddr_b = 3'(7 - a);
         step();
         chk("init_rvalid_a", rvalid_a, 1);
         chk("init_rvalid_b", rvalid_b, 1);
         chk("init_rdata_a", rdata_a, 0);
         chk("init_rdata_b", rdata_b, 0);
      end
      re_a = 0; re_b = 0;
      step();
      chk("rvalid_a_drop", rvalid_a, 0);
      chk("rvalid_b_drop", rvalid_b, 0);

      // Masked write
      we = 1; waddr = 3; wdata = 16'hFFFF; wmask = 4'hF;
      step();
      wdata = 16'h1234; wmask = 4'b0101;
      step();
      wdata = 16'h0000; wmask = 4'b0000;
      step();
      we = 0;
      re_a = 1; raddr_a = 3;
      step();
      chk("masked_r3", rdata_a, 16'hF2F4);
      chk("masked_rvalid", rvalid_a, 1);
      chk("masked_no_drop", wr_drop, 0);
      re_a = 0;
      step();
      chk("hold_rdata_a", rdata_a, 16'hF2F4);
      chk("hold_rvalid_a", rvalid_a, 0);

      // Bypass, full mask and partial mask
      we = 1; waddr = 5; wdata = 16'hABCD; wmask = 4'hF;
      re_a = 1; raddr_a = 5; re_b = 1; raddr_b = 5;
      step();
      chk("bypass_a", rdata_a, 16'hABCD);
      chk("bypass_b", rdata_b, 16'hABCD);
      waddr = 3; wdata = 16'h0000; wmask = 4'b1000;
      raddr_a = 3; raddr_b = 5;
      step();
      chk("bypass_part_a", rdata_a, 16'h02F4);
      chk("stored_r5_b", rdata_b, 16'hABCD);
      we = 0;
      step();
      chk("stored_r3_a", rdata_a, 16'h02F4);

      // Zero register
      we = 1; waddr = 0; wdata = 16'h5555; wmask = 4'hF;
      re_a = 1; raddr_a = 0; re_b = 0;
      step();
      chk("zero_same_cycle", rdata_a, 0);
      chk("zero_no_drop", wr_drop, 0);
      we = 0;
      step();
      chk("zero_read", rdata_a, 0);
      chk("zero_no_drop2", wr_drop, 0);

      // Fill r1..r7 then clear with a colliding write
      re_a = 0;
      for (int i = 1; i < 8; i++) begin
         we = 1; waddr = 3'(i); wdata = 16'(16'h1111 * i); wmask = 4'hF;
         step();
      end
      we = 0;
      re_a = 1; raddr_a = 7;
      step();
      chk("filled_r7", rdata_a, 16'h7777);
      clr = 1; we = 1; waddr = 2; wdata = 16'hBEEF; wmask = 4'hF;
      raddr_a = 1;
      step();
      chk("clr_wr_drop", wr_drop, 1);
      chk("clr_busy", busy, 1);
      chk("clr_cycle_read", rdata_a, 0);
      clr = 0; we = 0; raddr_a = 7;
      cnt = 0;
      for (int i = 0; i < 20 && busy; i++) begin
         cnt++;
         busy_before = busy;
         step();
         if (i == 0) chk("clr_drop_pulse_end", wr_drop, 0);
         if (busy_before) chk("busy_read_zero", rdata_a, 0);
      end
      chk("clr_busy_len", cnt, 8);
      for (int a = 0; a < 8; a++) begin
         re_a = 1; raddr_a = 3'(a);
         step();
         chk("post_clr_read", rdata_a, 0);
      end

      // Reset mid-sweep
      we = 1; waddr = 4; wdata = 16'h4444; wmask = 4'hF;
      re_a = 0;
      step();
      we = 0; re_a = 1; raddr_a = 4;
      step();
      chk("r4_value", rdata_a, 16'h4444);
      re_a = 0; re_b = 1; raddr_b = 6;
      clr = 1;
      step();
      clr = 0; we = 1; waddr = 1; wdata = 16'h9999;
      for (int i = 0; i < 4; i++) step();
      chk("sweep_drop_before_rst", wr_drop, 1);
      chk("sweep_rvalid_before_rst", rvalid_b, 1);
      chk("sweep_hold_before_rst", rdata_a, 16'h4444);
      #2;
      reset = 1;
      #1;
      chk("midrst_rdata_a", rdata_a, 0);
      chk("midrst_rvalid_b", rvalid_b, 0);
      chk("midrst_wr_drop", wr_drop, 0);
      chk("midrst_busy", busy, 1);
      idle_inputs();
      step();
      reset = 0;
      cnt = 0;
      for (int i = 0; i < 20 && busy; i++) begin
         cnt++;
         step();
      end
      chk("midrst_busy_len", cnt, 8);
      re_a = 1; raddr_a = 4;
      step();
      chk("after_midrst_r4", rdata_a, 0);
      chk("after_midrst_rvalid", rvalid_a, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
